sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, entry width in bits.
REQ-002 SHALL have parameter QUEUE_DEPTH, default 8, number of entries; legal values are powers of two, 2..256.
REQ-003 SHALL have parameter ALMOST_FULL_LEVEL, default QUEUE_DEPTH-1, occupancy at or above which SIG_ALMOST_FULL asserts; legal range 1..QUEUE_DEPTH.
REQ-004 SHALL use one clock and an asynchronous active-low reset, with ports as follows:
- SIG_CLK, input, 1 bit: clock; all state changes on the rising edge.
- SIG_RSTn, input, 1 bit: asynchronous active-low reset.
- CMD_PUSH, input, 1 bit: write DATA_TO_PUSH this cycle.
- CMD_POP, input, 1 bit: consume the head entry this cycle.
- CMD_FLUSH, input, 1 bit: synchronous clear of contents.
- DATA_TO_PUSH, input, DATA_WIDTH bits: write data.
- DATA_FROM_POP, output, DATA_WIDTH bits: head entry, first-word-fall-through.
- SIG_FULL, output, 1 bit: occupancy equals QUEUE_DEPTH.
- SIG_EMPTY, output, 1 bit: occupancy equals 0.
- SIG_ALMOST_FULL, output, 1 bit: occupancy is at least ALMOST_FULL_LEVEL.
- COUNT, output, $clog2(QUEUE_DEPTH)+1 bits: current occupancy.
- SIG_OVERFLOW, output, 1 bit: sticky; a push was attempted while full.
- SIG_UNDERFLOW, output, 1 bit: sticky; a pop was attempted while empty.

Function
REQ-005 SHALL store entries in a circular array indexed by write and read pointers of $clog2(QUEUE_DEPTH) bits, each wrapping from QUEUE_DEPTH-1 to 0.
REQ-006 SHALL make a push accepted when CMD_PUSH=1 and (SIG_FULL=0 or an accepted pop occurs in the same cycle).
- Effect: the entry is written at the write pointer and the write pointer increments.
REQ-007 SHALL make a pop accepted when CMD_POP=1 and SIG_EMPTY=0.
- Effect: the read pointer increments.
REQ-008 SHALL drive DATA_FROM_POP combinationally from the entry at the read pointer; the value is undefined-but-stable (last stored) when empty.
REQ-009 SHALL make a pushed word visible on DATA_FROM_POP in the cycle after the push edge (write-to-read latency 1), including when the FIFO was empty.
REQ-010 SHALL update COUNT on each edge as follows:
- +1 on an accepted push only.
- -1 on an accepted pop only.
- Unchanged when both are accepted or neither is.
REQ-011 SHALL, when empty, ignore a simultaneous push and pop as a pop: the push is accepted, the pop is rejected and sets SIG_UNDERFLOW, and COUNT becomes 1.
REQ-012 SHALL, when full, accept a simultaneous push and pop: COUNT stays QUEUE_DEPTH, SIG_OVERFLOW is not set, and the new word enters at the tail.
REQ-013 SHALL derive SIG_FULL, SIG_EMPTY and SIG_ALMOST_FULL combinationally from the COUNT register only (no input-to-flag paths).
REQ-014 SHALL set SIG_OVERFLOW on CMD_PUSH=1 while push is rejected, and set SIG_UNDERFLOW on CMD_POP=1 while empty; both hold until reset or flush.
REQ-015 SHALL have CMD_FLUSH=1 take priority over push and pop in that cycle:
- Pointers, COUNT and both sticky flags clear on the next edge.
- Array contents are not cleared.
REQ-016 SHALL not modify the storage array on rejected pushes.

Reset
REQ-017 SHALL, while SIG_RSTn=0 and independently of SIG_CLK, force the pointers and COUNT to 0 and SIG_OVERFLOW/SIG_UNDERFLOW to 0.
REQ-018 SHALL therefore present outputs during reset as: SIG_EMPTY=1, SIG_FULL=0, SIG_ALMOST_FULL=0.
REQ-019 SHALL reset the storage array to all zeros, so DATA_FROM_POP=0 after reset.
REQ-020 SHALL treat reset asserted mid-operation as discarding all contents; the first edge after release behaves as from empty.

Structure
REQ-021 SHALL place the Data32_T-style typedef and FIFO constants (depth limits, COUNT width function) in the shared Type package.
REQ-022 SHALL instantiate one sub-module, fifo_ptr: a parametrised wrapping pointer with increment enable, synchronous clear and async reset, used twice for the read and write pointers.
REQ-023 SHALL contain no latches and no combinational path from CMD_* to SIG_FULL/SIG_EMPTY.

Verification
REQ-024 SHALL cover fill and drain at DEPTH=8, WIDTH=32:
- Stimulus: push 0x10..0x17, then pop 8 times.
- Response: SIG_FULL=1 after the 8th push, COUNT=8; pops return 0x10..0x17 in order, then SIG_EMPTY=1.
REQ-025 SHALL cover overflow:
- Stimulus: 9th push (0xAA) while full.
- Response: rejected, SIG_OVERFLOW=1, COUNT=8, head still 0x10.
REQ-026 SHALL cover simultaneous push and pop:
- Stimulus: push/pop together when full with 0x55, and when empty with 0x66.
- Response: full case gives COUNT=8 with 0x55 at the tail; empty case gives COUNT=1, DATA_FROM_POP=0x66 next cycle, SIG_UNDERFLOW=1.
REQ-027 SHALL cover wrap-around:
- Stimulus: 20 interleaved push/pop pairs at occupancy 3.
- Response: data order preserved across pointer wrap; COUNT stays 3.
REQ-028 SHALL cover flush and reset mid-operation:
- Stimulus: CMD_FLUSH at COUNT=5, with CMD_PUSH=1 in the same cycle.
- Response: COUNT=0, SIG_EMPTY=1, flags cleared, push ignored.
- Stimulus: SIG_RSTn low mid-cycle.
- Response: outputs go to reset values immediately, without a clock edge.
REQ-029 SHALL cover the almost-full threshold:
- Stimulus: DEPTH=4, ALMOST_FULL_LEVEL=3.
- Response: SIG_ALMOST_FULL rises exactly when COUNT reaches 3.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared types, depth limits and width helpers for sync_fifo
package sync_fifo_pkg;

    typedef logic [31:0] data32_t;

    localparam int MIN_DEPTH     = 2;
    localparam int MAX_DEPTH     = 256;
    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 8;

    // COUNT must represent 0..depth inclusive, hence one bit more than the pointer.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic bit depth_legal(input int depth);
        return (depth >= MIN_DEPTH) && (depth <= MAX_DEPTH) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// rtl/sync_fifo_if.sv - command/data/status bundle between a FIFO user and sync_fifo
//   master: drives CMD_PUSH, CMD_POP, CMD_FLUSH, DATA_TO_PUSH; observes everything else
//   slave : the FIFO itself, the mirror image of master
interface sync_fifo_if
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_WIDTH,
    parameter int QUEUE_DEPTH = DEFAULT_DEPTH
);
    localparam int CW = count_width(QUEUE_DEPTH);

    logic                  CMD_PUSH;
    logic                  CMD_POP;
    logic                  CMD_FLUSH;
    logic [DATA_WIDTH-1:0] DATA_TO_PUSH;
    logic [DATA_WIDTH-1:0] DATA_FROM_POP;
    logic                  SIG_FULL;
    logic                  SIG_EMPTY;
    logic                  SIG_ALMOST_FULL;
    logic [CW-1:0]         COUNT;
    logic                  SIG_OVERFLOW;
    logic                  SIG_UNDERFLOW;

    modport master (
        output CMD_PUSH, CMD_POP, CMD_FLUSH, DATA_TO_PUSH,
        input  DATA_FROM_POP, SIG_FULL, SIG_EMPTY, SIG_ALMOST_FULL,
        input  COUNT, SIG_OVERFLOW, SIG_UNDERFLOW
    );

    modport slave (
        input  CMD_PUSH, CMD_POP, CMD_FLUSH, DATA_TO_PUSH,
        output DATA_FROM_POP, SIG_FULL, SIG_EMPTY, SIG_ALMOST_FULL,
        output COUNT, SIG_OVERFLOW, SIG_UNDERFLOW
    );

endinterface

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - wrapping pointer with increment enable, synchronous clear, async reset
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : advance by one, wrapping from 2**WIDTH-1 to 0
//   clr        : synchronous clear, wins over inc
//   ptr        : current pointer value
module fifo_ptr #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] ptr
);

    // Depth is a power of two, so natural binary overflow is the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + WIDTH'(1);
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous first-word-fall-through FIFO with sticky error flags
//   SIG_CLK  : clock, all state changes on the rising edge
//   SIG_RSTn : asynchronous active-low reset, clears pointers, count, flags and storage
//   bus      : sync_fifo_if.slave - push/pop/flush commands, write data, head data,
//              full/empty/almost-full, occupancy COUNT, sticky overflow/underflow
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH        = DEFAULT_WIDTH,
    parameter int QUEUE_DEPTH       = DEFAULT_DEPTH,
    parameter int ALMOST_FULL_LEVEL = QUEUE_DEPTH - 1
) (
    input  logic        SIG_CLK,
    input  logic        SIG_RSTn,
    sync_fifo_if.slave  bus
);

    localparam int PW = ptr_width(QUEUE_DEPTH);
    localparam int CW = count_width(QUEUE_DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(QUEUE_DEPTH);
    localparam logic [CW-1:0] AF_COUNT   = CW'(ALMOST_FULL_LEVEL);

    generate
        if (!depth_legal(QUEUE_DEPTH) || ALMOST_FULL_LEVEL < 1 || ALMOST_FULL_LEVEL > QUEUE_DEPTH) begin : g_bad_params
            $error("sync_fifo: illegal QUEUE_DEPTH or ALMOST_FULL_LEVEL");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [QUEUE_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;
    logic                  full;
    logic                  empty;
    logic                  pop_ok;
    logic                  push_ok;

    // Flags come from the count register only, so no CMD_* input reaches them.
    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // A pop frees a slot in the same cycle, so a push while full is still
    // accepted alongside it; a pop while empty is never accepted.
    assign pop_ok  = bus.CMD_POP && !empty;
    assign push_ok = bus.CMD_PUSH && (!full || pop_ok);

    fifo_ptr #(.WIDTH(PW)) u_wr_ptr (
        .clk   (SIG_CLK),
        .rst_n (SIG_RSTn),
        .inc   (push_ok),
        .clr   (bus.CMD_FLUSH),
        .ptr   (wr_ptr)
    );

    fifo_ptr #(.WIDTH(PW)) u_rd_ptr (
        .clk   (SIG_CLK),
        .rst_n (SIG_RSTn),
        .inc   (pop_ok),
        .clr   (bus.CMD_FLUSH),
        .ptr   (rd_ptr)
    );

    // Storage is cleared only by reset; flush leaves contents in place.
    always_ff @(posedge SIG_CLK or negedge SIG_RSTn) begin
        if (!SIG_RSTn) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (!bus.CMD_FLUSH && push_ok) begin
            mem[wr_ptr] <= bus.DATA_TO_PUSH;
        end
    end

    always_ff @(posedge SIG_CLK or negedge SIG_RSTn) begin
        if (!SIG_RSTn) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (bus.CMD_FLUSH) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok && !pop_ok) begin
                count <= count + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CW'(1);
            end
            if (bus.CMD_PUSH && !push_ok) begin
                overflow <= 1'b1;
            end
            if (bus.CMD_POP && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    assign bus.DATA_FROM_POP   = mem[rd_ptr];
    assign bus.SIG_FULL        = full;
    assign bus.SIG_EMPTY       = empty;
    assign bus.SIG_ALMOST_FULL = (count >= AF_COUNT);
    assign bus.COUNT           = count;
    assign bus.SIG_OVERFLOW    = overflow;
    assign bus.SIG_UNDERFLOW   = underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - self-checking bench for sync_fifo (depth 8 and depth 4 instances)
module tb_sync_fifo;
    import sync_fifo_pkg::*;

    localparam int DA = 8;
    localparam int DB = 4;
    localparam int AFA = DA - 1;
    localparam int AFB = 3;

    logic    clk = 1'b0;
    logic    rst_n;
    logic    push = 1'b0;
    logic    pop = 1'b0;
    logic    flush = 1'b0;
    data32_t din = '0;
    bit      check_on = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sync_fifo_if #(.DATA_WIDTH(32), .QUEUE_DEPTH(DA)) ifa ();
    sync_fifo_if #(.DATA_WIDTH(32), .QUEUE_DEPTH(DB)) ifb ();

    assign ifa.CMD_PUSH = push;
    assign ifa.CMD_POP = pop;
    assign ifa.CMD_FLUSH = flush;
    assign ifa.DATA_TO_PUSH = din;
    assign ifb.CMD_PUSH = push;
    assign ifb.CMD_POP = pop;
    assign ifb.CMD_FLUSH = flush;
    assign ifb.DATA_TO_PUSH = din;

    sync_fifo #(.DATA_WIDTH(32), .QUEUE_DEPTH(DA)) dut_a (
        .SIG_CLK  (clk),
        .SIG_RSTn (rst_n),
        .bus      (ifa)
    );

    sync_fifo #(.DATA_WIDTH(32), .QUEUE_DEPTH(DB), .ALMOST_FULL_LEVEL(AFB)) dut_b (
        .SIG_CLK  (clk),
        .SIG_RSTn (rst_n),
        .bus      (ifb)
    );

    // Reference model: a plain queue per instance plus sticky flags.
    data32_t qa[$];
    data32_t qb[$];
    bit ovf[2];
    bit unf[2];

    task automatic model_reset();
        qa.delete();
        qb.delete();
        ovf[0] = 0; ovf[1] = 0;
        unf[0] = 0; unf[1] = 0;
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int sz;
            int dep;
            bit pop_acc;
            bit push_acc;
            sz  = (i == 0) ? qa.size() : qb.size();
            dep = (i == 0) ? DA : DB;
            if (flush) begin
                if (i == 0) qa.delete(); else qb.delete();
                ovf[i] = 0;
                unf[i] = 0;
            end else begin
                pop_acc  = pop && (sz > 0);
                push_acc = push && ((sz < dep) || pop_acc);
                if (push && !push_acc) ovf[i] = 1;
                if (pop && sz == 0) unf[i] = 1;
                if (i == 0) begin
                    if (pop_acc) void'(qa.pop_front());
                    if (push_acc) qa.push_back(din);
                end else begin
                    if (pop_acc) void'(qb.pop_front());
                    if (push_acc) qb.push_back(din);
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; returns at the following falling edge.
    task automatic step(input bit p, input bit q, input bit f, input data32_t d);
        push = p; pop = q; flush = f; din = d;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        push = 0; pop = 0; flush = 0;
    endtask

    // Continuous comparison against the model on every falling edge.
    always @(negedge clk) begin
        if (check_on) begin
            chk("a_count", 32'(ifa.COUNT), 32'(qa.size()));
            chk("a_full", 32'(ifa.SIG_FULL), 32'(qa.size() == DA));
            chk("a_empty", 32'(ifa.SIG_EMPTY), 32'(qa.size() == 0));
            chk("a_afull", 32'(ifa.SIG_ALMOST_FULL), 32'(qa.size() >= AFA));
            chk("a_ovf", 32'(ifa.SIG_OVERFLOW), 32'(ovf[0]));
            chk("a_unf", 32'(ifa.SIG_UNDERFLOW), 32'(unf[0]));
            if (qa.size() > 0) chk("a_head", ifa.DATA_FROM_POP, qa[0]);
            chk("b_count", 32'(ifb.COUNT), 32'(qb.size()));
            chk("b_full", 32'(ifb.SIG_FULL), 32'(qb.size() == DB));
            chk("b_empty", 32'(ifb.SIG_EMPTY), 32'(qb.size() == 0));
            chk("b_afull", 32'(ifb.SIG_ALMOST_FULL), 32'(qb.size() >= AFB));
            chk("b_ovf", 32'(ifb.SIG_OVERFLOW), 32'(ovf[1]));
            chk("b_unf", 32'(ifb.SIG_UNDERFLOW), 32'(unf[1]));
            if (qb.size() > 0) chk("b_head", ifb.DATA_FROM_POP, qb[0]);
        end
    end

    initial begin
        rst_n = 1'b0;
        model_reset();
        #12;
        chk("rst_a_empty", 32'(ifa.SIG_EMPTY), 32'd1);
        chk("rst_a_full", 32'(ifa.SIG_FULL), 32'd0);
        chk("rst_a_afull", 32'(ifa.SIG_ALMOST_FULL), 32'd0);
        chk("rst_a_count", 32'(ifa.COUNT), 32'd0);
        chk("rst_a_data", ifa.DATA_FROM_POP, 32'd0);
        chk("rst_b_empty", 32'(ifb.SIG_EMPTY), 32'd1);
        chk("rst_b_data", ifb.DATA_FROM_POP, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_on = 1'b1;

        // Fill: depth 8 takes all, depth 4 saturates and flags overflow.
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, 32'h10 + 32'(i));
            chk("fill_b_afull", 32'(ifb.SIG_ALMOST_FULL), 32'(((i + 1) < 4 ? (i + 1) : 4) >= 3));
        end
        chk("fill_a_full", 32'(ifa.SIG_FULL), 32'd1);
        chk("fill_a_count", 32'(ifa.COUNT), 32'd8);
        chk("fill_a_head", ifa.DATA_FROM_POP, 32'h10);

        step(1, 0, 0, 32'hAA);
        chk("ovf_a_flag", 32'(ifa.SIG_OVERFLOW), 32'd1);
        chk("ovf_a_count", 32'(ifa.COUNT), 32'd8);
        chk("ovf_a_head", ifa.DATA_FROM_POP, 32'h10);

        step(1, 1, 0, 32'h55);
        chk("simfull_count", 32'(ifa.COUNT), 32'd8);
        chk("simfull_head", ifa.DATA_FROM_POP, 32'h11);

        for (int i = 0; i < 8; i++) begin
            chk("drain_data", ifa.DATA_FROM_POP, (i < 7) ? 32'h11 + 32'(i) : 32'h55);
            step(0, 1, 0, '0);
        end
        chk("drain_empty", 32'(ifa.SIG_EMPTY), 32'd1);

        step(1, 1, 0, 32'h66);
        chk("simempty_count", 32'(ifa.COUNT), 32'd1);
        chk("simempty_data", ifa.DATA_FROM_POP, 32'h66);
        chk("simempty_unf", 32'(ifa.SIG_UNDERFLOW), 32'd1);

        // Wrap-around at occupancy 3.
        step(0, 0, 1, '0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, $urandom);
        for (int i = 0; i < 20; i++) step(1, 1, 0, $urandom);
        chk("wrap_count", 32'(ifa.COUNT), 32'd3);

        // Flush at count 5 with a push in the same cycle.
        step(1, 0, 0, 32'h71);
        step(1, 0, 0, 32'h72);
        chk("preflush_count", 32'(ifa.COUNT), 32'd5);
        chk("preflush_b_ovf", 32'(ifb.SIG_OVERFLOW), 32'd1);
        step(1, 0, 1, 32'h77);
        chk("flush_count", 32'(ifa.COUNT), 32'd0);
        chk("flush_empty", 32'(ifa.SIG_EMPTY), 32'd1);
        chk("flush_ovf", 32'(ifa.SIG_OVERFLOW), 32'd0);
        chk("flush_unf", 32'(ifa.SIG_UNDERFLOW), 32'd0);
        chk("flush_b_ovf", 32'(ifb.SIG_OVERFLOW), 32'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 3, $urandom);
        end

        // Asynchronous reset between edges.
        step(1, 0, 0, 32'h81);
        step(1, 0, 0, 32'h82);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_empty", 32'(ifa.SIG_EMPTY), 32'd1);
        chk("async_full", 32'(ifa.SIG_FULL), 32'd0);
        chk("async_afull", 32'(ifa.SIG_ALMOST_FULL), 32'd0);
        chk("async_count", 32'(ifa.COUNT), 32'd0);
        chk("async_data", ifa.DATA_FROM_POP, 32'd0);
        chk("async_b_count", 32'(ifb.COUNT), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0, 32'h99);
        chk("post_rst_count", 32'(ifa.COUNT), 32'd1);
        chk("post_rst_data", ifa.DATA_FROM_POP, 32'h99);

        @(negedge clk);
        check_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
